// File: rtl/ledwalker_if.sv
`default_nettype none
// ============================================================================
// Module   : ledwalker_if
// Brief    : Control/status bundle between a step source and the LED walker.
//            The walker owns the slave side; the driver of enable and the
//            square wave owns the master side.
// Revision : 1.0 - initial release
// ============================================================================
interface ledwalker_if #(
    parameter int LGNLEDS = 3
) ();
    localparam int c_nleds = 1 << LGNLEDS;

    logic                i_en;
    logic                i_pps;
    logic [c_nleds-1:0]  o_led;
    logic [LGNLEDS-1:0]  o_pos;
    logic                o_sweep_done;
    logic [15:0]         o_sweeps;

    modport master (
        output i_en,
        output i_pps,
        input  o_led,
        input  o_pos,
        input  o_sweep_done,
        input  o_sweeps
    );

    modport slave (
        input  i_en,
        input  i_pps,
        output o_led,
        output o_pos,
        output o_sweep_done,
        output o_sweeps
    );
endinterface
`default_nettype wire

// File: rtl/ledwalker.sv
`default_nettype none
// ============================================================================
// Module   : ledwalker
// Brief    : Bounces one lit LED across the bank, one position per edge of a
//            synchronised square wave, leaving a PWM-dimmed trail on the LED
//            just vacated. Counts completed round trips.
// Revision : 1.0 - initial release
// ============================================================================
module ledwalker #(
    parameter int LGNLEDS   = 3,
    parameter int PWM_BITS  = 4,
    parameter int DIM_LEVEL = 4
) (
    input  wire logic  i_clk,
    input  wire logic  i_reset,
    ledwalker_if.slave bus
);
    localparam int                c_nleds = 1 << LGNLEDS;
    localparam logic [LGNLEDS-1:0] c_last = LGNLEDS'(c_nleds - 1);
    localparam logic [PWM_BITS:0]  c_dim  = (PWM_BITS + 1)'(DIM_LEVEL);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RIGHT = 2'd1,
        ST_LEFT  = 2'd2
    } state_t;

    logic                r_ff1, r_ff2, r_ff3;
    logic [1:0]          r_settle;
    logic                w_settled;
    logic                w_step;
    logic [PWM_BITS-1:0] r_pwm;
    logic                w_pwm_on;
    state_t              r_state;
    logic [LGNLEDS-1:0]  r_pos;
    logic [LGNLEDS-1:0]  r_trail;
    logic                r_trail_valid;
    logic                r_sweep_done;
    logic [15:0]         r_sweeps;
    logic [LGNLEDS-1:0]  w_pos_inc;
    logic [LGNLEDS-1:0]  w_pos_dec;
    logic [c_nleds-1:0]  w_led_next;
    logic [c_nleds-1:0]  r_led;

    // Three-flop synchroniser; ff2/ff3 disagreeing marks an edge of i_pps.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ff1 <= 1'b0;
            r_ff2 <= 1'b0;
            r_ff3 <= 1'b0;
        end else begin
            r_ff1 <= bus.i_pps;
            r_ff2 <= r_ff1;
            r_ff3 <= r_ff2;
        end
    end

    // Blanking counter: masks the false edge seen when i_pps is already high
    // as the synchroniser fills after reset.
    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_settle <= 2'd0;
        else if (r_settle != 2'd3)
            r_settle <= r_settle + 2'd1;
    end

    assign w_settled = (r_settle == 2'd3);
    assign w_step    = (r_ff2 ^ r_ff3) && w_settled;

    // Free-running PWM counter; compare is one bit wider so DIM_LEVEL may
    // equal the full period (always on).
    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_pwm <= '0;
        else
            r_pwm <= r_pwm + 1'b1;
    end

    assign w_pwm_on  = ({1'b0, r_pwm} < c_dim);
    assign w_pos_inc = r_pos + 1'b1;
    assign w_pos_dec = r_pos - 1'b1;

    // Walker state machine: enable drop beats a step, reset beats both.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= ST_IDLE;
            r_pos         <= '0;
            r_trail       <= '0;
            r_trail_valid <= 1'b0;
            r_sweep_done  <= 1'b0;
            r_sweeps      <= 16'd0;
        end else begin
            r_sweep_done <= 1'b0;
            if (!bus.i_en) begin
                r_state       <= ST_IDLE;
                r_pos         <= '0;
                r_trail_valid <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_state       <= ST_RIGHT;
                        r_pos         <= '0;
                        r_trail_valid <= 1'b0;
                    end
                    ST_RIGHT: begin
                        if (w_step) begin
                            r_trail       <= r_pos;
                            r_trail_valid <= 1'b1;
                            r_pos         <= w_pos_inc;
                            if (w_pos_inc == c_last)
                                r_state <= ST_LEFT;
                        end
                    end
                    ST_LEFT: begin
                        if (w_step) begin
                            r_trail <= r_pos;
                            r_pos   <= w_pos_dec;
                            if (w_pos_dec == '0) begin
                                r_state      <= ST_RIGHT;
                                r_sweep_done <= 1'b1;
                                r_sweeps     <= r_sweeps + 16'd1;
                            end
                        end
                    end
                    default: begin
                        r_state       <= ST_IDLE;
                        r_pos         <= '0;
                        r_trail_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

    // LED pattern from the current lead, trail and PWM phase.
    always_comb begin
        w_led_next = '0;
        if (r_state != ST_IDLE) begin
            w_led_next[r_pos] = 1'b1;
            if (r_trail_valid && w_pwm_on)
                w_led_next[r_trail] = 1'b1;
        end
    end

    // Register the LED drive so the pins never see combinational glitches.
    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_led <= '0;
        else
            r_led <= w_led_next;
    end

    assign bus.o_led        = r_led;
    assign bus.o_pos        = r_pos;
    assign bus.o_sweep_done = r_sweep_done;
    assign bus.o_sweeps     = r_sweeps;
endmodule
`default_nettype wire

// File: tb/tb_ledwalker.sv
`default_nettype none
// ============================================================================
// Module   : tb_ledwalker
// Brief    : Self-checking bench for ledwalker. Three instances (trail duty
//            4/16, 0 and 16) share one stimulus stream; a step-count model
//            predicts position, LEDs, pulse and sweep count every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ledwalker;
    localparam int LG   = 3;
    localparam int N    = 1 << LG;
    localparam int PER  = 2 * (N - 1);
    localparam int HIST = 16384;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;
    logic pps = 1'b0;

    always #5 clk = ~clk;

    ledwalker_if #(.LGNLEDS(LG)) bus4  ();
    ledwalker_if #(.LGNLEDS(LG)) bus0  ();
    ledwalker_if #(.LGNLEDS(LG)) bus16 ();

    assign bus4.i_en   = en;
    assign bus4.i_pps  = pps;
    assign bus0.i_en   = en;
    assign bus0.i_pps  = pps;
    assign bus16.i_en  = en;
    assign bus16.i_pps = pps;

    ledwalker #(.LGNLEDS(LG), .PWM_BITS(4), .DIM_LEVEL(4))  dut   (.i_clk(clk), .i_reset(rst), .bus(bus4));
    ledwalker #(.LGNLEDS(LG), .PWM_BITS(4), .DIM_LEVEL(0))  dut0  (.i_clk(clk), .i_reset(rst), .bus(bus0));
    ledwalker #(.LGNLEDS(LG), .PWM_BITS(4), .DIM_LEVEL(16)) dut16 (.i_clk(clk), .i_reset(rst), .bus(bus16));

    int total = 0;
    int bad   = 0;

    // Reference model: everything follows from the number of steps taken
    // since the walk was enabled, plus the sampled history of i_pps.
    int         m_edge     = 0;
    int         m_rst_edge = 0;
    logic       pps_s [0:HIST-1];
    bit         m_run      = 1'b0;
    int         m_n        = 0;
    int         m_sweeps   = 0;
    bit         m_done     = 1'b0;
    logic [7:0] m_led4     = 8'h00;
    logic [7:0] m_led0     = 8'h00;
    logic [7:0] m_led16    = 8'h00;

    function automatic int posf(input int n);
        int k;
        k = n % PER;
        return (k <= N - 1) ? k : PER - k;
    endfunction

    function automatic logic [7:0] ledf(input bit run, input int n, input bit on);
        logic [7:0] v;
        logic [7:0] one;
        one = 8'h01;
        if (!run) return 8'h00;
        v = one << posf(n);
        if (n > 0 && on) v = v | (one << posf(n - 1));
        return v;
    endfunction

    task automatic model_edge(input bit r, input bit en_v, input bit pps_v);
        bit prun;
        int pn;
        int phase;
        bit stp;
        m_edge        = m_edge + 1;
        pps_s[m_edge] = pps_v;
        prun          = m_run;
        pn            = m_n;
        if (r) begin
            m_rst_edge = m_edge;
            m_run      = 1'b0;
            m_n        = 0;
            m_sweeps   = 0;
            m_done     = 1'b0;
            m_led4     = 8'h00;
            m_led0     = 8'h00;
            m_led16    = 8'h00;
        end else begin
            // Edge seen at sample k acts two samples later; the first three
            // cycles after reset are blanked.
            phase  = (m_edge - 1 - m_rst_edge) % 16;
            stp    = (m_edge - m_rst_edge >= 4) && (pps_s[m_edge-2] != pps_s[m_edge-3]);
            m_done = 1'b0;
            if (!en_v) begin
                m_run = 1'b0;
                m_n   = 0;
            end else if (!prun) begin
                m_run = 1'b1;
                m_n   = 0;
            end else if (stp) begin
                m_n = m_n + 1;
                if (m_n % PER == 0) begin
                    m_done   = 1'b1;
                    m_sweeps = (m_sweeps + 1) % 65536;
                end
            end
            m_led4  = ledf(prun, pn, phase < 4);
            m_led0  = ledf(prun, pn, 1'b0);
            m_led16 = ledf(prun, pn, 1'b1);
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, check.
    task automatic tick(input bit r, input bit en_v, input bit pps_v);
        rst = r;
        en  = en_v;
        pps = pps_v;
        @(posedge clk);
        model_edge(r, en_v, pps_v);
        #1;
        chk("m_pos",    32'(bus4.o_pos),        m_run ? 32'(posf(m_n)) : 32'd0);
        chk("m_led4",   32'(bus4.o_led),        32'(m_led4));
        chk("m_led0",   32'(bus0.o_led),        32'(m_led0));
        chk("m_led16",  32'(bus16.o_led),       32'(m_led16));
        chk("m_done",   32'(bus4.o_sweep_done), 32'(m_done));
        chk("m_sweeps", 32'(bus4.o_sweeps),     32'(m_sweeps));
    endtask

    typedef struct {
        bit         rst;
        bit         en;
        bit         pps;
        int         reps;
        int         exp_pos;
        logic [7:0] mask;
        logic [7:0] exp_led;
        int         exp_sweeps;
    } vec_t;

    vec_t tbl [16];

    initial begin
        int cnt4, cnt0, cnt16, hold, p0;
        bit pv, rv, ev;

        // Reset with i_pps high, then one full round trip, one edge per row.
        tbl[0]  = '{1'b1, 1'b1, 1'b1,  2, 0, 8'hFF, 8'h00, 0};
        tbl[1]  = '{1'b0, 1'b1, 1'b1, 10, 0, 8'hFF, 8'h01, 0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0,  5, 1, 8'hFE, 8'h02, 0};
        tbl[3]  = '{1'b0, 1'b1, 1'b1,  5, 2, 8'hFD, 8'h04, 0};
        tbl[4]  = '{1'b0, 1'b1, 1'b0,  5, 3, 8'hFB, 8'h08, 0};
        tbl[5]  = '{1'b0, 1'b1, 1'b1,  5, 4, 8'hF7, 8'h10, 0};
        tbl[6]  = '{1'b0, 1'b1, 1'b0,  5, 5, 8'hEF, 8'h20, 0};
        tbl[7]  = '{1'b0, 1'b1, 1'b1,  5, 6, 8'hDF, 8'h40, 0};
        tbl[8]  = '{1'b0, 1'b1, 1'b0,  5, 7, 8'hBF, 8'h80, 0};
        tbl[9]  = '{1'b0, 1'b1, 1'b1,  5, 6, 8'h7F, 8'h40, 0};
        tbl[10] = '{1'b0, 1'b1, 1'b0,  5, 5, 8'hBF, 8'h20, 0};
        tbl[11] = '{1'b0, 1'b1, 1'b1,  5, 4, 8'hDF, 8'h10, 0};
        tbl[12] = '{1'b0, 1'b1, 1'b0,  5, 3, 8'hEF, 8'h08, 0};
        tbl[13] = '{1'b0, 1'b1, 1'b1,  5, 2, 8'hF7, 8'h04, 0};
        tbl[14] = '{1'b0, 1'b1, 1'b0,  5, 1, 8'hFB, 8'h02, 0};
        tbl[15] = '{1'b0, 1'b1, 1'b1,  5, 0, 8'hFD, 8'h01, 1};

        for (int i = 0; i < 16; i++) begin
            repeat (tbl[i].reps) tick(tbl[i].rst, tbl[i].en, tbl[i].pps);
            chk("tbl_pos",    32'(bus4.o_pos),                32'(tbl[i].exp_pos));
            chk("tbl_led",    32'(bus4.o_led & tbl[i].mask),  32'(tbl[i].exp_led));
            chk("tbl_sweeps", 32'(bus4.o_sweeps),             32'(tbl[i].exp_sweeps));
        end

        // Trail duty at position 0 (trail on bit 1) over one PWM period.
        cnt4 = 0; cnt0 = 0; cnt16 = 0;
        for (int i = 0; i < 16; i++) begin
            tick(1'b0, 1'b1, 1'b1);
            cnt4  = cnt4  + int'(bus4.o_led[1]);
            cnt0  = cnt0  + int'(bus0.o_led[1]);
            cnt16 = cnt16 + int'(bus16.o_led[1]);
            chk("lead_bit0", 32'(bus4.o_led[0]), 32'd1);
        end
        chk("trail_duty4",  32'(cnt4),  32'd4);
        chk("trail_duty0",  32'(cnt0),  32'd0);
        chk("trail_duty16", 32'(cnt16), 32'd16);

        // Walk to position 3, drop enable, then re-enable.
        repeat (5) tick(1'b0, 1'b1, 1'b0);
        repeat (5) tick(1'b0, 1'b1, 1'b1);
        repeat (5) tick(1'b0, 1'b1, 1'b0);
        chk("en_pos3", 32'(bus4.o_pos), 32'd3);
        tick(1'b0, 1'b0, 1'b0);
        chk("endrop_pos", 32'(bus4.o_pos), 32'd0);
        tick(1'b0, 1'b0, 1'b0);
        chk("endrop_led",    32'(bus4.o_led),    32'd0);
        chk("endrop_sweeps", 32'(bus4.o_sweeps), 32'd1);
        repeat (3) tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        chk("reen_pos", 32'(bus4.o_pos), 32'd0);
        tick(1'b0, 1'b1, 1'b0);
        chk("reen_led", 32'(bus4.o_led), 32'h01);
        repeat (4) tick(1'b0, 1'b1, 1'b0);

        // One-cycle glitch: two steps on consecutive edges.
        p0 = int'(bus4.o_pos);
        tick(1'b0, 1'b1, 1'b1);
        tick(1'b0, 1'b1, 1'b0);
        chk("glitch_hold", 32'(bus4.o_pos), 32'(p0));
        tick(1'b0, 1'b1, 1'b0);
        chk("glitch_step1", 32'(bus4.o_pos), 32'(p0 + 1));
        tick(1'b0, 1'b1, 1'b0);
        chk("glitch_step2", 32'(bus4.o_pos), 32'(p0 + 2));
        repeat (4) tick(1'b0, 1'b1, 1'b0);

        // Reset landing on the same edge as a step.
        tick(1'b0, 1'b1, 1'b1);
        tick(1'b0, 1'b1, 1'b1);
        tick(1'b1, 1'b1, 1'b1);
        chk("rststep_pos",    32'(bus4.o_pos),        32'd0);
        chk("rststep_led",    32'(bus4.o_led),        32'd0);
        chk("rststep_done",   32'(bus4.o_sweep_done), 32'd0);
        chk("rststep_sweeps", 32'(bus4.o_sweeps),     32'd0);

        // Randomised run: variable spacing (including glitches), enable
        // drops and rare resets, all tracked by the model every cycle.
        pv   = 1'b1;
        hold = 1;
        for (int i = 0; i < 4000; i++) begin
            rv = ($urandom_range(0, 399) == 0);
            ev = ($urandom_range(0, 99) != 0);
            hold = hold - 1;
            if (hold <= 0) begin
                pv   = ~pv;
                hold = ($urandom_range(0, 7) == 0) ? 1 : int'($urandom_range(2, 6));
            end
            tick(rv, ev, pv);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/ledwalker.md
# ledwalker

Downstream consumer of the 1 Hz square-wave divider output. It synchronises that square wave and treats every edge, rising or falling, as one step. On each step it moves a single lit LED back and forth across an LED bank. The LED it just left stays on dimly through a PWM trail. It reports a pulse and a running count for each completed round trip.

## Interface

Parameters:
- LGNLEDS, 3: log2 of LED count; NLEDS = 1<<LGNLEDS, must be ≥ 2.
- PWM_BITS, 4: width of the free-running PWM counter.
- DIM_LEVEL, 4: trail duty in counts out of 2^PWM_BITS; legal range 0..2^PWM_BITS.

Ports:
- i_clk  in  1  sole clock.
- i_reset  in  1  synchronous, active-high reset.
- i_en  in  1  run enable; low forces IDLE.
- i_pps  in  1  asynchronous square wave; each edge is one step.
- o_led  out  NLEDS  LED drive, registered.
- o_pos  out  LGNLEDS  current lead position.
- o_sweep_done  out  1  one-cycle pulse when a round trip completes.
- o_sweeps  out  16  count of completed round trips, wraps at 2^16.

## Operation

- Input sync:
  - Chain ff1 ← i_pps, ff2 ← ff1, ff3 ← ff2.
  - step = (ff2 ^ ff3) && settled.
- Settle counter (2 bits): held at 0 by reset, then counts to 3 and saturates. settled = (count == 3), so steps are suppressed for 3 cycles after reset. This hides the spurious edge when i_pps is already 1 at reset.
- Reset values:
  - ff1..ff3 = 0; state = IDLE; o_pos = 0; trail_valid = 0.
  - o_led = 0; o_sweep_done = 0; o_sweeps = 0; PWM counter = 0.
- FSM states: IDLE, RIGHT, LEFT.
  - IDLE: o_pos = 0, trail_valid = 0, steps ignored. When i_en = 1, go to RIGHT on the next edge.
  - RIGHT, on step: trail ← o_pos, trail_valid ← 1, o_pos ← o_pos+1. If the new o_pos = NLEDS-1, go to LEFT.
  - LEFT, on step: trail ← o_pos, o_pos ← o_pos-1. If the new o_pos = 0, go to RIGHT, pulse o_sweep_done, and increment o_sweeps.
  - Any state with i_en = 0: go to IDLE on the next edge, o_pos ← 0, trail_valid ← 0. o_sweeps is retained; only reset clears it.
  - Priority: i_reset > i_en = 0 > step.
- PWM: counter free-runs from reset, wrapping at 2^PWM_BITS. pwm_on = (counter < DIM_LEVEL), so DIM_LEVEL = 0 means never on and 2^PWM_BITS means always on.
- LED drive, registered:
  - In IDLE, o_led = 0.
  - Otherwise o_led[o_pos] = 1, and o_led[trail] = pwm_on when trail_valid.
  - All other LEDs are 0.
  - trail never equals o_pos.
- Arithmetic: o_pos, trail and the PWM counter are unsigned and never exceed their ranges. o_sweeps wraps from 0xFFFF to 0.

## Timing

- An i_pps edge first sampled into ff1 at clock edge k produces step during the cycle after edge k+1. o_pos and the state update at edge k+2.
- o_led reflects the new o_pos and trail one edge later (k+3).
- o_sweep_done is high for exactly the one cycle after the edge at which o_pos returns to 0.
- o_sweeps updates on that same edge.
- Enable:
  - i_en rising in IDLE: state is RIGHT after one edge, and o_led[0] = 1 one edge later.
  - i_en falling: state is IDLE and o_pos = 0 after one edge; o_led = 0 one edge later.
- Reset asserted mid-operation returns every output to its reset value at the next edge.
- Reset overrides a step coincident with it.
- A one-cycle i_pps glitch gives two steps on consecutive cycles, both honoured.
- Edges closer together than one cycle are not guaranteed to be resolved.

## Test plan

All scenarios use the defaults (NLEDS = 8, PWM_BITS = 4, DIM_LEVEL = 4).

- Reset with i_pps held at 1, i_en = 1, then 10 idle cycles → o_pos = 0, o_sweeps = 0, no step, o_led = 0x01 after enable settles.
- i_en = 1, then 7 i_pps edges spaced ≥ 4 cycles → o_pos = 7, state LEFT, o_led[7] = 1. o_led[6] is high for exactly 4 of every 16 cycles; other bits are 0.
- Continue to 14 edges total → o_pos = 0, o_sweep_done high for exactly 1 cycle, o_sweeps = 1. o_led[0] = 1 with the trail on bit 1.
- At o_pos = 3, drop i_en → IDLE next cycle, o_led = 0x00 the cycle after, o_sweeps unchanged. Re-enable → restarts at o_pos 0 heading RIGHT with no trail.
- Pulse i_pps high for one cycle → o_pos advances by 2 on consecutive cycles. Assert i_reset coincident with a step → o_pos = 0 and all outputs at reset values.
- Rebuild with DIM_LEVEL = 0 → trail LED never lit. Rebuild with DIM_LEVEL = 16 → trail LED constantly lit.
